mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between the instruction-fetch stage (word reads)
//  and the MEM stage (loads/stores of 1/2/4 bytes). Sequences multi-byte transfers as
//  little-endian byte bursts, latches each request at grant, and returns an assembled word
//  with a one-cycle done pulse. Sits between pc_reg/mem stage and the RAM/IO pins.
// PARAMETERS
//  ADDR_W    32       address width of requester and RAM ports
//  IO_SEL    2'b11    value of addr[17:16] that selects the IO space
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous reset, active-low
//  if_req         in   1       fetch request, level, held until if_done or flush
//  if_addr        in   ADDR_W  fetch word address
//  if_flush       in   1       abort any pending/active fetch (branch redirect)
//  if_done        out  1       one-cycle pulse, if_rdata valid
//  if_rdata       out  32      fetched word {b3,b2,b1,b0}
//  mem_req        in   1       load/store request, level, held until mem_done
//  mem_we         in   1       1 = store, 0 = load
//  mem_size       in   2       00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes (11 treated as 10)
//  mem_addr       in   ADDR_W  first byte address
//  mem_wdata      in   32      store data, byte i = wdata[8i+7:8i]
//  mem_done       out  1       one-cycle pulse, load/store complete
//  mem_rdata      out  32      load data, zero-extended above mem_size
//  mem_busy       out  1       high while a MEM transfer is granted (pipeline stall source)
//  ram_din        in   8       RAM read byte, 1-cycle read latency
//  io_buffer_full in   1       IO output buffer full
//  ram_a          out  ADDR_W  RAM byte address
//  ram_dout       out  8       RAM write byte
//  ram_wr         out  1       1 = write ram_dout to ram_a this cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; latched addr/size/data cleared.
//  - States: IDLE, RD, WR, IO_WAIT. Transfers are never split or pre-empted except by flush.
//  - Arbitration in IDLE, on each edge: mem_req wins over if_req (older instruction);
//    grant latches addr, size (N = 1, 2 or 4 bytes) and wdata. Fetch always has N = 4.
//  - Read (RD), grant at edge 0: cycles 1..N drive ram_a = addr+i-1, ram_wr = 0;
//    ram_din of byte i is captured at the end of cycle i+2. done pulses in cycle N+2
//    with rdata; state is IDLE in cycle N+2, so a new grant is possible at that edge.
//    Word fetch: request edge 0 -> if_done in cycle 6.
//  - Write (WR): cycles 1..N drive ram_a = addr+i-1, ram_dout = byte i-1, ram_wr = 1.
//    mem_done is in cycle N+1.
//  - IO: a store with addr[17:16] == IO_SEL while io_buffer_full = 1 enters IO_WAIT before
//    each byte (ram_wr = 0, ram_a held). It resumes the cycle after io_buffer_full = 0.
//    IO loads never wait.
//  - Address arithmetic is mod 2^ADDR_W (wrap at all-ones, no fault).
//  - if_flush: an active fetch returns to IDLE at the next edge with no if_done and
//    discards its bytes. If flush coincides with the done cycle, if_done is forced 0.
//    Flush has no effect on MEM transfers. A requester that drops its req mid-transfer is
//    ignored until done.
//  - mem_busy = 1 from the grant edge through the mem_done cycle inclusive.
//  - ram_a = 0 and ram_wr = 0 in IDLE. rdata holds its value after done.
// TESTING
//  1. Fetch only: if_addr=0x100 and RAM bytes 13,00,50,00 -> ram_a 0x100..0x103 in
//     cycles 1-4, if_done in cycle 6 with if_rdata=0x00500013.
//  2. Simultaneous: if_req and mem_req (lb, 0x200) on the same edge -> mem_done first with
//     mem_rdata=0x000000XX, then the fetch grant at the mem_done edge.
//  3. sw 0xDEADBEEF to 0x1FFFE -> ram_wr on 0x1FFFE..0x20001 with bytes EF,BE,AD,DE,
//     mem_done in cycle 5.
//  4. sb to 0x30000 with io_buffer_full held 3 cycles -> ram_wr stays 0 for 3 cycles,
//     then one write, mem_done.
//  5. if_flush in cycle 3 of a fetch -> no if_done, IDLE next cycle, and a new fetch
//     completes correctly.
//  6. rst pulled low mid-store -> ram_wr=0 immediately; after release, IDLE with
//     all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter: shares one 8-bit RAM port between instruction fetch and the
// MEM stage, sequencing little-endian bursts and returning assembled words with done pulses.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter logic [1:0]  IO_SEL = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic              mem_busy,
   input  logic [7:0]        ram_din,
   input  logic              io_buffer_full,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRd     = 2'd1;
   localparam logic [1:0] StWr     = 2'd2;
   localparam logic [1:0] StIoWait = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              is_mem_q, is_mem_d;
   logic              we_q, we_d;
   logic [2:0]        n_q, n_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;

   logic [ADDR_W-1:0] cur_a;
   logic [ADDR_W-1:0] nxt_a;
   logic [1:0]        cap_idx;
   logic              rd_addr_phase;

   function automatic logic is_io(input logic [ADDR_W-1:0] a);
      return a[17:16] == IO_SEL;
   endfunction

   assign cur_a = base_q + ADDR_W'(cnt_q);
   assign nxt_a = cur_a + ADDR_W'(1);
   // Byte returned this cycle was addressed one cycle earlier.
   assign cap_idx = cnt_q[1:0] - 2'd1;
   assign rd_addr_phase = (state_q == StRd) && (cnt_q < n_q);

   always_comb begin
      state_d     = state_q;
      is_mem_d    = is_mem_q;
      we_d        = we_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            buf_d = '0;
            // A requester still sees its done pulse this cycle; do not re-grant it.
            if (mem_req && !mem_done_q) begin
               is_mem_d = 1'b1;
               we_d     = mem_we;
               base_d   = mem_addr;
               wdata_d  = mem_wdata;
               n_d      = (mem_size == 2'b00) ? 3'd1 : (mem_size == 2'b01) ? 3'd2 : 3'd4;
               if (!mem_we)                               state_d = StRd;
               else if (is_io(mem_addr) && io_buffer_full) state_d = StIoWait;
               else                                       state_d = StWr;
            end else if (if_req && !if_flush && !if_done_q) begin
               is_mem_d = 1'b0;
               we_d     = 1'b0;
               base_d   = if_addr;
               wdata_d  = '0;
               n_d      = 3'd4;
               state_d  = StRd;
            end
         end
         StRd: begin
            if (cnt_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = ram_din;
            if (!is_mem_q && if_flush) begin
               state_d = StIdle;
            end else if (cnt_q == n_q) begin
               state_d = StIdle;
               if (is_mem_q) begin
                  mem_rdata_d = buf_d;
                  mem_done_d  = 1'b1;
               end else begin
                  if_rdata_d = buf_d;
                  if_done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StWr: begin
            if (cnt_q == n_q - 3'd1) begin
               state_d    = StIdle;
               mem_done_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + 3'd1;
               state_d = (is_io(nxt_a) && io_buffer_full) ? StIoWait : StWr;
            end
         end
         StIoWait: begin
            if (!io_buffer_full) state_d = StWr;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         is_mem_q    <= 1'b0;
         we_q        <= 1'b0;
         n_q         <= '0;
         cnt_q       <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_mem_q    <= is_mem_d;
         we_q        <= we_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

   assign ram_a     = (rd_addr_phase || state_q == StWr || state_q == StIoWait) ? cur_a : '0;
   assign ram_wr    = (state_q == StWr);
   assign ram_dout  = (state_q == StWr) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
   assign if_done   = if_done_q & ~if_flush;
   assign if_rdata  = if_rdata_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_busy  = ((state_q != StIdle) && is_mem_q) || mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized transactions against a transaction-level memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, if_done;
   logic [31:0] if_addr, if_rdata;
   logic        mem_req, mem_we, mem_done, mem_busy;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  ram_din = 8'h00;
   logic        io_buffer_full;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic        ram_clear;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
      .ram_din(ram_din), .io_buffer_full(io_buffer_full),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr)
   );

   // RAM with one-cycle registered read; addresses folded to a small array.
   logic [7:0] ram_arr [0:16383];

   function automatic logic [13:0] ridx(input logic [31:0] a);
      return {a[17:16], a[11:0]};
   endfunction

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 16384; i++) ram_arr[i] <= 8'(i) ^ 8'h5A;
      end else if (ram_wr) begin
         ram_arr[ridx(ram_a)] <= ram_dout;
      end
      ram_din <= ram_arr[ridx(ram_a)];
   end

   // Reference memory contents at transaction level.
   logic [7:0] model_mem [logic [31:0]];

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input int n);
      for (int k = 0; k < n; k++) model_mem[a + 32'(k)] = 8'(wd >> (8 * k));
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   function automatic int size_bytes(input logic is_mem, input logic [1:0] size);
      if (!is_mem) return 4;
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // One transaction from an idle negedge; checks bus, latency, rdata, pulse width and hold.
   task automatic run_txn(input string tag, input logic is_mem, input logic we,
                          input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic full,
                          input logic [31:0] exp_rdata, input int exp_lat);
      int          n;
      int          lat;
      logic [31:0] got;
      logic        done;
      n = size_bytes(is_mem, size);
      io_buffer_full = full;
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat = 0;
      got = '0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) check_bit({tag, " busy c1"}, mem_busy, is_mem);
         if (c <= n) begin
            check({tag, " ram_a"}, ram_a, addr + 32'(c - 1));
            check_bit({tag, " ram_wr"}, ram_wr, is_mem && we);
            if (is_mem && we) check({tag, " ram_dout"}, {24'h0, ram_dout},
                                    {24'h0, 8'(wdata >> (8 * (c - 1)))});
         end
         done = is_mem ? mem_done : if_done;
         if (done) begin
            lat = c;
            got = is_mem ? mem_rdata : if_rdata;
            check_bit({tag, " busy done"}, mem_busy, is_mem);
         end
      end
      mem_req = 1'b0;
      if_req = 1'b0;
      io_buffer_full = 1'b0;
      check({tag, " latency"}, lat, exp_lat);
      if (!(is_mem && we)) check({tag, " rdata"}, got, exp_rdata);
      @(negedge clk);
      check_bit({tag, " done width"}, is_mem ? mem_done : if_done, 1'b0);
      check_bit({tag, " busy after"}, mem_busy, 1'b0);
      if (!(is_mem && we)) check({tag, " rdata hold"}, is_mem ? mem_rdata : if_rdata, exp_rdata);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 2))
         0:       return 32'h0000_0400 + 32'($urandom_range(0, 31));
         1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         default: return 32'h0002_FFFC + 32'($urandom_range(0, 7));
      endcase
   endfunction

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        full;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          kind, n, lat, md, id;
      logic [31:0] a, wd, ex, ab;
      logic [1:0]  sz;
      logic        full, io_hit;

      vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'h0050_0013, 1'b0, 32'h0, 5};
      vecs[1]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_3CA7, 1'b0, 32'h0, 3};
      vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b0, 32'h0050_0013, 6};
      vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0200, 32'h0, 1'b0, 32'h0000_00A7, 3};
      vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 32'h0000_3CA7, 4};
      vecs[5]  = '{1'b1, 1'b1, 2'd2, 32'h0001_FFFE, 32'hDEAD_BEEF, 1'b0, 32'h0, 5};
      vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h0001_FFFE, 32'h0, 1'b0, 32'hDEAD_BEEF, 6};
      vecs[7]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0, 1'b0, 32'h0050_0013, 6};
      vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h1234_ABCD, 1'b0, 32'h0, 3};
      vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h5BAB_CDA4, 6};
      vecs[10] = '{1'b1, 1'b1, 2'd0, 32'h0003_0001, 32'h0000_0077, 1'b0, 32'h0, 2};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0003_0000, 32'h0, 1'b1, 32'h5958_775A, 6};
      vecs[12] = '{1'b1, 1'b0, 2'd0, 32'h0003_0000, 32'h0, 1'b1, 32'h0000_005A, 3};
      vecs[13] = '{1'b1, 1'b1, 2'd0, 32'h0000_0400, 32'h0000_0011, 1'b1, 32'h0, 2};
      vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h0000_0400, 32'h0, 1'b0, 32'h0000_0011, 3};

      rst = 1'b0; ram_clear = 1'b1;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
      io_buffer_full = 1'b0;
      repeat (2) @(negedge clk);
      check_bit("reset if_done", if_done, 1'b0);
      check("reset if_rdata", if_rdata, 32'h0);
      check_bit("reset mem_done", mem_done, 1'b0);
      check("reset mem_rdata", mem_rdata, 32'h0);
      check_bit("reset mem_busy", mem_busy, 1'b0);
      check("reset ram_a", ram_a, 32'h0);
      check_bit("reset ram_wr", ram_wr, 1'b0);
      check("reset ram_dout", {24'h0, ram_dout}, 32'h0);
      ram_clear = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 15; v++) begin
         run_txn($sformatf("vec%0d", v), vecs[v].is_mem, vecs[v].we, vecs[v].size,
                 vecs[v].addr, vecs[v].wdata, vecs[v].full, vecs[v].exp_rdata, vecs[v].exp_lat);
         if (vecs[v].is_mem && vecs[v].we)
            model_write(vecs[v].addr, vecs[v].wdata, size_bytes(1'b1, vecs[v].size));
      end

      // Simultaneous requests: load wins, fetch granted at the load's done edge.
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h200;
      if_req = 1'b1; if_addr = 32'h100;
      md = 0; id = 0;
      for (int c = 1; c <= 20 && id == 0; c++) begin
         @(negedge clk);
         if (c == 1) check_bit("simul busy c1", mem_busy, 1'b1);
         if (c == 4) begin
            check("simul fetch ram_a", ram_a, 32'h100);
            check_bit("simul busy c4", mem_busy, 1'b0);
         end
         if (mem_done && md == 0) begin
            md = c;
            check("simul mem_rdata", mem_rdata, 32'h0000_00A7);
            mem_req = 1'b0;
         end
         if (if_done) begin
            id = c;
            check("simul if_rdata", if_rdata, 32'h0050_0013);
            if_req = 1'b0;
         end
      end
      check("simul mem_done cycle", md, 3);
      check("simul if_done cycle", id, 9);
      mem_req = 1'b0; if_req = 1'b0;
      @(negedge clk);

      // IO store held off by a full buffer for three cycles.
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h3_0000;
      mem_wdata = 32'h0000_005C; io_buffer_full = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check_bit($sformatf("io wait wr c%0d", c), ram_wr, 1'b0);
         check($sformatf("io wait ram_a c%0d", c), ram_a, 32'h3_0000);
         check_bit($sformatf("io wait done c%0d", c), mem_done, 1'b0);
         check_bit($sformatf("io wait busy c%0d", c), mem_busy, 1'b1);
      end
      io_buffer_full = 1'b0;
      @(negedge clk);
      check_bit("io write wr", ram_wr, 1'b1);
      check("io write ram_a", ram_a, 32'h3_0000);
      check("io write dout", {24'h0, ram_dout}, 32'h5C);
      @(negedge clk);
      check_bit("io write done", mem_done, 1'b1);
      mem_req = 1'b0;
      model_write(32'h3_0000, 32'h5C, 1);
      @(negedge clk);

      // Flush in cycle 3 of a fetch, then a fresh fetch.
      if_req = 1'b1; if_addr = 32'h100;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 if_flush = 1'b1;
      @(negedge clk);
      check("flush c3 ram_a", ram_a, 32'h102);
      check_bit("flush c3 if_done", if_done, 1'b0);
      @(posedge clk); #1 if_flush = 1'b0; if_addr = 32'h1_FFFE;
      @(negedge clk);
      check("flush idle ram_a", ram_a, 32'h0);
      check_bit("flush idle if_done", if_done, 1'b0);
      run_txn("flush refetch", 1'b0, 1'b0, 2'd2, 32'h1_FFFE, 32'h0, 1'b0, 32'hDEAD_BEEF, 6);

      // Flush coinciding with the done cycle suppresses if_done.
      if_req = 1'b1; if_addr = 32'h100;
      repeat (5) @(negedge clk);
      check_bit("flushdone pre", if_done, 1'b0);
      @(posedge clk); #1 if_flush = 1'b1;
      @(negedge clk);
      check_bit("flushdone forced", if_done, 1'b0);
      if_req = 1'b0;
      @(posedge clk); #1 if_flush = 1'b0;
      @(negedge clk);
      check_bit("flushdone after", if_done, 1'b0);
      check("flushdone idle ram_a", ram_a, 32'h0);

      for (int t = 0; t < 200; t++) begin
         kind = $urandom_range(0, 2);
         a = pick_addr();
         sz = 2'($urandom_range(0, 3));
         wd = $urandom;
         n = size_bytes(kind != 0, sz);
         io_hit = 1'b0;
         ex = '0;
         for (int k = 0; k < n; k++) begin
            ab = a + 32'(k);
            if (ab[17:16] == 2'b11) io_hit = 1'b1;
            if (kind != 2) ex = ex | (32'(model_rd(ab)) << (8 * k));
         end
         full = (kind == 2 && io_hit) ? 1'b0 : 1'($urandom_range(0, 1));
         lat = (kind == 2) ? n + 1 : n + 2;
         run_txn($sformatf("rand%0d", t), kind != 0, kind == 2, sz, a, wd, full, ex, lat);
         if (kind == 2) model_write(a, wd, n);
      end

      // Asynchronous reset in the middle of a word store.
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h500;
      mem_wdata = 32'h0102_0304;
      repeat (2) @(negedge clk);
      check_bit("rst store active", ram_wr, 1'b1);
      rst = 1'b0;
      #1;
      check_bit("rst ram_wr async", ram_wr, 1'b0);
      check("rst ram_a async", ram_a, 32'h0);
      check_bit("rst busy async", mem_busy, 1'b0);
      mem_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_bit("post-rst if_done", if_done, 1'b0);
      check("post-rst if_rdata", if_rdata, 32'h0);
      check_bit("post-rst mem_done", mem_done, 1'b0);
      check("post-rst mem_rdata", mem_rdata, 32'h0);
      check_bit("post-rst mem_busy", mem_busy, 1'b0);
      check("post-rst ram_a", ram_a, 32'h0);
      check_bit("post-rst ram_wr", ram_wr, 1'b0);
      check("post-rst ram_dout", {24'h0, ram_dout}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
